dmem_stage: RTL

Parametrised pipeline memory stage with an internal word-organised data memory. It sits between execute and writeback and replaces the pass-through memory stage. It performs RV32 byte/half/word loads and stores with a configurable access latency, and stalls upstream while an access is in flight. It flags misaligned and out-of-range accesses and passes non-memory instructions through with one cycle of latency.

---
 rtl/dmem_stage.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_stage.sv
// dmem_stage: pipeline memory stage with an internal word-organised data memory.
// It performs RV32 byte/half/word loads and stores with a configurable access
// latency, flags misaligned and out-of-range accesses, and forwards non-memory
// instructions with one cycle of latency.
module dmem_stage #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_store_data,
  input  logic [31:0] in_alu_result,
  input  logic [4:0]  in_rd,
  input  logic        stall_in,
  output logic        stall_out,
  output logic        out_valid,
  output logic [4:0]  out_rd,
  output logic [31:0] out_result,
  output logic        out_data_ready,
  output logic        out_exc,
  output logic [1:0]  out_exc_cause
);

  localparam int          AW           = $clog2(DEPTH);
  localparam logic [31:0] ADDR_LIMIT   = 32'(4 * DEPTH);
  localparam logic [3:0]  CNT_INIT     = 4'(LATENCY - 1);
  localparam bit          SINGLE_CYCLE = (LATENCY == 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      cnt_reg, cnt_next;
  logic            capture;

  // Request captured at consumption, replayed at completion.
  logic            req_read_reg, req_write_reg;
  logic [2:0]      req_funct3_reg;
  logic [AW+1:0]   req_addr_reg;
  logic [31:0]     req_data_reg;
  logic [4:0]      req_rd_reg;

  logic [31:0]     mem [DEPTH];

  logic            consume, mem_op, misaligned, out_of_range, fault;
  logic [1:0]      fault_cause;
  logic            op_read, op_write;
  logic [2:0]      op_funct3;
  logic [AW+1:0]   op_addr;
  logic [31:0]     op_data;
  logic [4:0]      op_rd;
  logic [AW-1:0]   op_idx;
  logic            complete, mem_we;
  logic [31:0]     rd_word, rd_shifted, load_data, wr_data;
  logic [3:0]      wr_be;

  // Consumption decision and fault classification of the incoming instruction.
  always_comb begin
    consume      = (state_reg == IDLE) && in_valid && !stall_in;
    mem_op       = in_mem_read || in_mem_write;
    misaligned   = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                   ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
    out_of_range = (in_addr >= ADDR_LIMIT);
    fault        = mem_op && (misaligned || out_of_range);
    fault_cause  = misaligned ? 2'b01 : 2'b10;
  end

  // Active operation: live inputs in IDLE (single-cycle path), captured request in BUSY.
  always_comb begin
    if (state_reg == BUSY) begin
      op_read   = req_read_reg;
      op_write  = req_write_reg;
      op_funct3 = req_funct3_reg;
      op_addr   = req_addr_reg;
      op_data   = req_data_reg;
      op_rd     = req_rd_reg;
    end else begin
      op_read   = in_mem_read;
      op_write  = in_mem_write;
      op_funct3 = in_funct3;
      op_addr   = in_addr[AW+1:0];
      op_data   = in_store_data;
      op_rd     = in_rd;
    end
    op_idx   = op_addr[AW+1:2];
    complete = (SINGLE_CYCLE && consume && mem_op && !fault) ||
               ((state_reg == BUSY) && !stall_in && (cnt_reg == 4'd1));
    // Gating with rst keeps a held reset from ever committing a store.
    mem_we   = rst && complete && op_write;
  end

  // Load lane extraction and store byte-enable/lane replication.
  always_comb begin
    rd_word    = mem[op_idx];
    rd_shifted = rd_word >> {op_addr[1:0], 3'b000};
    case (op_funct3)
      3'b000:  load_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      3'b001:  load_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      3'b100:  load_data = {24'd0, rd_shifted[7:0]};
      3'b101:  load_data = {16'd0, rd_shifted[15:0]};
      default: load_data = rd_word;
    endcase
    case (op_funct3[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << op_addr[1:0];
        wr_data = {4{op_data[7:0]}};
      end
      2'b01: begin
        wr_be   = 4'b0011 << op_addr[1:0];
        wr_data = {2{op_data[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = op_data;
      end
    endcase
  end

  // Byte-enabled memory write at the completion edge; contents are never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[op_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // State register: FSM state, latency counter and captured request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      req_read_reg   <= 1'b0;
      req_write_reg  <= 1'b0;
      req_funct3_reg <= 3'd0;
      req_addr_reg   <= '0;
      req_data_reg   <= 32'd0;
      req_rd_reg     <= 5'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (capture) begin
        req_read_reg   <= in_mem_read;
        req_write_reg  <= in_mem_write;
        req_funct3_reg <= in_funct3;
        req_addr_reg   <= in_addr[AW+1:0];
        req_data_reg   <= in_store_data;
        req_rd_reg     <= in_rd;
      end
    end
  end

  // Next-state logic: enter BUSY for legal multi-cycle ops, count down while not stalled.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (consume && mem_op && !fault && !SINGLE_CYCLE) begin
          state_next = BUSY;
          cnt_next   = CNT_INIT;
          capture    = 1'b1;
        end
      end
      BUSY: begin
        if (!stall_in) begin
          cnt_next = cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic derived from state and the output register.
  always_comb begin
    stall_out      = (state_reg == BUSY) || stall_in;
    out_data_ready = out_valid && !out_exc && (out_rd != 5'd0);
  end

  // Output register: completion, pass-through, fault, or bubble; frozen on stall_in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      out_rd        <= 5'd0;
      out_result    <= 32'd0;
      out_exc       <= 1'b0;
      out_exc_cause <= 2'b00;
    end else if (!stall_in) begin
      if (complete) begin
        out_valid     <= 1'b1;
        out_rd        <= op_read ? op_rd : 5'd0;
        out_result    <= op_read ? load_data : 32'd0;
        out_exc       <= 1'b0;
        out_exc_cause <= 2'b00;
      end else if (consume && !mem_op) begin
        out_valid     <= 1'b1;
        out_rd        <= in_rd;
        out_result    <= in_alu_result;
        out_exc       <= 1'b0;
        out_exc_cause <= 2'b00;
      end else if (consume && fault) begin
        out_valid     <= 1'b1;
        out_rd        <= 5'd0;
        out_result    <= 32'd0;
        out_exc       <= 1'b1;
        out_exc_cause <= fault_cause;
      end else begin
        out_valid     <= 1'b0;
        out_rd        <= 5'd0;
        out_result    <= 32'd0;
        out_exc       <= 1'b0;
        out_exc_cause <= 2'b00;
      end
    end
  end

endmodule
